// File: rtl/capture_gate_pkg.sv
// capture_gate_pkg: shared state encoding and status widths for the capture gate
package capture_gate_pkg;
    localparam int MISSW = 8;
    typedef enum logic [1:0] {IDLE, DELAY, OPEN} state_t;
endpackage

// File: rtl/capture_gate_ctrl.sv
// capture_gate_ctrl: capture edge detect, delay/open window FSM, status and missed-trigger count
module capture_gate_ctrl
    import capture_gate_pkg::*;
#(
    parameter int NCHAN = 2,
    parameter int CNTW  = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             capture_i,
    input  logic             abort_i,
    input  logic [CNTW-1:0]  delay_i,
    input  logic [CNTW-1:0]  length_i,
    input  logic [NCHAN-1:0] chan_en_i,
    output logic             gate_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [MISSW-1:0] missed_o,
    output logic [NCHAN-1:0] chan_en_o
);
    state_t          state;
    logic [1:0]      cap_q;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] len_l;
    logic            trig;

    assign trig = cap_q[0] & ~cap_q[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cap_q     <= '0;
            cnt       <= '0;
            len_l     <= '0;
            chan_en_o <= '0;
            gate_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            missed_o  <= '0;
        end else begin
            cap_q  <= {cap_q[0], capture_i};
            done_o <= 1'b0;
            if (trig && state != IDLE && missed_o != {MISSW{1'b1}})
                missed_o <= missed_o + MISSW'(1);
            case (state)
                IDLE: if (trig) begin
                    chan_en_o <= chan_en_i;
                    len_l     <= length_i;
                    if (length_i == '0) begin
                        done_o <= 1'b1;
                    end else if (delay_i == '0) begin
                        state  <= OPEN;
                        cnt    <= length_i - CNTW'(1);
                        gate_o <= 1'b1;
                        busy_o <= 1'b1;
                    end else begin
                        state  <= DELAY;
                        cnt    <= delay_i - CNTW'(1);
                        busy_o <= 1'b1;
                    end
                end
                DELAY: if (abort_i) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end else if (cnt == '0) begin
                    state  <= OPEN;
                    cnt    <= len_l - CNTW'(1);
                    gate_o <= 1'b1;
                end else begin
                    cnt <= cnt - CNTW'(1);
                end
                OPEN: if (abort_i || cnt == '0) begin
                    // abort outranks expiry: only a natural end reports done
                    state  <= IDLE;
                    gate_o <= 1'b0;
                    busy_o <= 1'b0;
                    done_o <= ~abort_i;
                end else begin
                    cnt <= cnt - CNTW'(1);
                end
                default: begin
                    state  <= IDLE;
                    gate_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/axis_capture_gate.sv
// axis_capture_gate: windowed, per-channel gating of free-running AXI4-Stream ADC data
module axis_capture_gate
    import capture_gate_pkg::*;
#(
    parameter int NCHAN = 2,
    parameter int DW    = 128,
    parameter int CNTW  = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                capture_i,
    input  logic                abort_i,
    input  logic [CNTW-1:0]     delay_i,
    input  logic [CNTW-1:0]     length_i,
    input  logic [NCHAN-1:0]    chan_en_i,
    input  logic [NCHAN*DW-1:0] s_tdata,
    input  logic [NCHAN-1:0]    s_tvalid,
    output logic [NCHAN-1:0]    s_tready,
    output logic [NCHAN*DW-1:0] m_tdata,
    output logic [NCHAN-1:0]    m_tvalid,
    output logic                gate_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [MISSW-1:0]    missed_o
);
    logic [NCHAN-1:0] chan_en_l;
    logic             unused_ok;

    // ADC streams are free-running, so their valid carries no information
    assign unused_ok = ^s_tvalid;
    assign s_tready  = '1;

    capture_gate_ctrl #(.NCHAN(NCHAN), .CNTW(CNTW)) u_ctrl (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .capture_i (capture_i),
        .abort_i   (abort_i),
        .delay_i   (delay_i),
        .length_i  (length_i),
        .chan_en_i (chan_en_i),
        .gate_o    (gate_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .missed_o  (missed_o),
        .chan_en_o (chan_en_l)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) m_tvalid <= '0;
        else m_tvalid <= '1;
    end

    for (genvar n = 0; n < NCHAN; n++) begin : g_ch
        logic [DW-1:0] q;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) q <= '0;
            else q <= (gate_o && chan_en_l[n]) ? s_tdata[n*DW +: DW] : '0;
        end
        assign m_tdata[n*DW +: DW] = q;
    end
endmodule

// File: tb/tb_axis_capture_gate.sv
// tb_axis_capture_gate: directed windows, retrigger, abort, saturation and async reset checks
module tb_axis_capture_gate;
    logic         aclk, aresetn, capture_i, abort_i;
    logic [15:0]  delay_i, length_i;
    logic [1:0]   chan_en_i, s_tvalid, s_tready, m_tvalid;
    logic [255:0] s_tdata, m_tdata;
    logic         gate_o, busy_o, done_o;
    logic [7:0]   missed_o;
    logic [31:0]  beat;
    int           n_checks, n_fail;

    axis_capture_gate dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .capture_i (capture_i),
        .abort_i   (abort_i),
        .delay_i   (delay_i),
        .length_i  (length_i),
        .chan_en_i (chan_en_i),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .gate_o    (gate_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .missed_o  (missed_o)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // ramp changes 2 time units after each edge, so at edge+1 it still shows the beat just sampled
    initial begin
        beat    = '0;
        s_tdata = '0;
        forever begin
            @(posedge aclk);
            #2;
            beat    = beat + 32'd1;
            s_tdata = {~{4{beat}}, {4{beat}}};
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // i counts edges from E0 (capture first sampled high); ab is the sample after which abort is raised
    task automatic run_window(input int d, input int l, input logic [1:0] en, input int ab, input bit retrig);
        int a;
        bit gate_e, busy_e, done_e, dwin;
        a         = (ab < 0) ? 1 << 30 : ab;
        delay_i   = 16'(d);
        length_i  = 16'(l);
        chan_en_i = en;
        capture_i = 1'b1;
        for (int i = 0; i <= d + l + 3; i++) begin
            tick;
            gate_e = l > 0 && i >= 1 + d && i <= d + l && i <= a;
            busy_e = l > 0 && i >= 1 && i <= d + l && i <= a;
            done_e = (l == 0) ? (i == 1) : (i == 1 + d + l && i <= a);
            dwin   = l > 0 && i >= 2 + d && i <= 1 + d + l && i <= a + 1;
            check("gate", gate_o, gate_e);
            check("busy", busy_o, busy_e);
            check("done", done_o, done_e);
            check("tdata", m_tdata, dwin ? (s_tdata & {{128{en[1]}}, {128{en[0]}}}) : 256'd0);
            capture_i = retrig && (i == 20 || i == 40 || i == 60);
            abort_i   = (i == ab);
        end
        capture_i = 1'b0;
        abort_i   = 1'b0;
    endtask

    initial begin
        int gates, dones, rises;
        logic gprev;
        n_checks  = 0;
        n_fail    = 0;
        aresetn   = 1'b1;
        capture_i = 1'b0;
        abort_i   = 1'b0;
        delay_i   = '0;
        length_i  = '0;
        chan_en_i = '0;
        s_tvalid  = '0;
        #2 aresetn = 1'b0;
        tick;
        tick;
        check("rst_gate", gate_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_missed", missed_o, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("tready", s_tready, 2'b11);
        aresetn = 1'b1;
        tick;
        check("tvalid_up", m_tvalid, 2'b11);
        tick;

        run_window(0, 4, 2'b11, -1, 0);
        run_window(64, 32, 2'b01, -1, 0);
        run_window(5, 0, 2'b11, -1, 0);
        run_window(10, 100, 2'b11, -1, 1);
        check("missed_retrig", missed_o, 3);

        // held capture level must open exactly one window
        delay_i   = 16'd10;
        length_i  = 16'd100;
        chan_en_i = 2'b10;
        capture_i = 1'b1;
        gates = 0;
        dones = 0;
        rises = 0;
        gprev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick;
            gates += int'(gate_o);
            dones += int'(done_o);
            rises += int'(gate_o & ~gprev);
            gprev = gate_o;
        end
        capture_i = 1'b0;
        tick;
        tick;
        check("hold_gate_cycles", 256'(gates), 100);
        check("hold_rises", 256'(rises), 1);
        check("hold_dones", 256'(dones), 1);
        check("hold_missed", missed_o, 3);

        run_window(20, 5, 2'b11, 5, 0);
        run_window(0, 2, 2'b10, -1, 0);
        run_window(0, 4, 2'b11, 4, 0);
        run_window(3, 3, 2'b01, -1, 0);
        check("abort_missed", missed_o, 3);

        // saturate missed_o inside one long window, then abort it
        delay_i   = 16'd0;
        length_i  = 16'd1000;
        chan_en_i = 2'b11;
        capture_i = 1'b1;
        tick;
        capture_i = 1'b0;
        tick;
        for (int i = 0; i < 300; i++) begin
            capture_i = 1'b1;
            tick;
            capture_i = 1'b0;
            tick;
        end
        tick;
        tick;
        check("missed_sat", missed_o, 255);
        check("sat_gate", gate_o, 1);
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        check("sat_abort_gate", gate_o, 0);
        check("sat_abort_done", done_o, 0);
        tick;
        check("sat_abort_done2", done_o, 0);

        // async reset mid-window
        length_i  = 16'd50;
        capture_i = 1'b1;
        tick;
        capture_i = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("pre_rst_gate", gate_o, 1);
        #2 aresetn = 1'b0;
        #1;
        check("arst_gate", gate_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_missed", missed_o, 0);
        check("arst_tvalid", m_tvalid, 0);
        check("arst_tdata", m_tdata, 0);
        tick;
        aresetn = 1'b1;
        tick;
        check("post_rst_tvalid", m_tvalid, 2'b11);
        check("post_rst_missed", missed_o, 0);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            tick;
            dones += int'(done_o) + int'(gate_o);
        end
        check("post_rst_quiet", 256'(dones), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_capture_gate.md
Name: axis_capture_gate

Overview:
Parametrised capture gate for NCHAN AXI4-Stream ADC channels ahead of the biquad filters and capture buffers. A rising edge on capture_i arms a window. After a programmable delay, each enabled channel passes its ADC data for a programmable number of beats. Outside the window the output is zero-filled. It supersedes the fixed three-SRL delay gate and adds runtime delay/length, a channel mask, abort and status.

Parameters:
NCHAN, 2, number of ADC channels gated together
DW, 128, tdata width per channel (8 x 16-bit samples)
CNTW, 16, width of the delay and length counters

Ports:
aclk  in  1  stream clock; all logic is synchronous to it
aresetn  in  1  asynchronous, active-low reset
capture_i  in  1  capture request, synchronous to aclk; rising edge triggers
abort_i  in  1  synchronous abort of an armed/open window
delay_i  in  CNTW  beats from trigger to window open; latched at trigger
length_i  in  CNTW  window length in beats; latched at trigger
chan_en_i  in  NCHAN  per-channel pass enable; latched at trigger
s_tdata  in  NCHAN*DW  ADC data; channel n at [n*DW +: DW]
s_tvalid  in  NCHAN  ADC valid, ignored; ADC streams are free-running
s_tready  out  NCHAN  tied to all ones
m_tdata  out  NCHAN*DW  gated data
m_tvalid  out  NCHAN  output valid
gate_o  out  1  window open
busy_o  out  1  FSM not IDLE
done_o  out  1  one-cycle pulse at window completion
missed_o  out  8  saturating count of triggers ignored while busy

Behaviour:
- Reset (aresetn low, asynchronous):
  - FSM to IDLE.
  - m_tdata=0, m_tvalid=0, gate_o=0, busy_o=0, done_o=0, missed_o=0.
  - Capture edge registers cleared.
  - Reset asserted mid-window drops the gate immediately and produces no done.
- After reset release:
  - m_tvalid is driven all ones from the first aclk edge onward.
- Edge detect:
  - cap_q[1:0] is a shift register of capture_i.
  - trig = cap_q[0] & ~cap_q[1].
  - If capture_i is first sampled high at edge E0, trig is true in the cycle after E0 and acts at edge E1.
  - A level held high gives exactly one trigger.
- FSM states: IDLE, DELAY, OPEN.
  - IDLE, trig, length_i==0: stay IDLE. Pulse done_o at E1. gate_o never rises.
  - IDLE, trig, delay_i==0: go to OPEN and load cnt=length_i-1.
  - IDLE, trig, otherwise: go to DELAY and load cnt=delay_i-1. Latch delay, length and chan_en at E1.
  - DELAY: decrement cnt. When cnt==0, go to OPEN and load cnt=length-1. DELAY therefore lasts exactly D cycles.
  - OPEN: gate_o=1. Decrement cnt. When cnt==0, go to IDLE and pulse done_o at that edge. Open lasts exactly L cycles; gate_o rises after edge E1+D.
  - abort_i in DELAY or OPEN: go to IDLE at the next edge. gate_o falls and no done_o is pulsed.
  - abort_i and counter expiry on the same edge: abort wins, no done_o.
  - abort_i in IDLE: no effect. When abort_i and trig coincide in IDLE, the trigger is accepted.
- Missed triggers:
  - trig while busy_o=1 is ignored and increments missed_o.
  - missed_o saturates at 255 and clears only on reset.
- Output registers, one cycle of latency, per channel n:
  - m_tdata[n] <= (gate_o & chan_en_l[n]) ? s_tdata[n] : 0.
  - Beats sampled during the L open cycles appear on m_tdata one cycle later.
  - Beats are passed bit-exact, low 4 pad bits included.
- Status outputs:
  - busy_o = (state != IDLE), registered.
  - done_o is high for exactly one cycle.
- Counter range:
  - delay_i and length_i up to 2^CNTW-1.
  - The counters never wrap; the state exit is taken at cnt==0.

Decomposition:
- Package capture_gate_pkg: state enum (IDLE, DELAY, OPEN) and the missed-counter width constant (8).
- Sub-module capture_gate_ctrl holds the edge detect, FSM, counters, status and missed counter. Its outputs are gate_o and the latched chan_en.
- The top level holds the NCHAN-wide output data register, generated per channel.

Test Plan:
- capture_i rises at E0 with D=0, L=4, chan_en=2'b11 and an incrementing ramp on both channels:
  - gate_o is high after E1 for 4 cycles.
  - m_tdata carries 4 consecutive ramp beats on both channels, zero otherwise.
  - done_o pulses once; busy_o is high for 4 cycles.
- D=64, L=32, chan_en=2'b01:
  - gate_o rises exactly 64 cycles after E1.
  - Channel 1 is always zero; channel 0 carries 32 beats.
- L=0, D=5:
  - done_o pulses at E1, gate_o stays 0, busy_o stays 0, m_tdata stays all zero.
- With D=10, L=100, retrigger capture_i 3 times during the window:
  - missed_o=3 and the window length is unchanged.
  - Next, hold capture_i high for 1000 cycles: exactly one window.
- abort_i during DELAY, and separately at the last OPEN cycle (coinciding with expiry):
  - gate_o falls next edge, no done_o, and a new trigger is accepted immediately.
- Assert aresetn low mid-window:
  - All outputs go to 0 asynchronously, before the next aclk edge.
  - After release, m_tvalid rises and missed_o=0.
